// File: rtl/jts16_ram_arb_pkg.sv
// Shared types and default SDRAM region bases for the work RAM / dump arbiter.
package jts16_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DUMP
  } owner_t;

  localparam logic [21:0] DEF_VRAM_OFFSET = 22'h10_0000;
  localparam logic [21:0] DEF_RAM_OFFSET  = 22'h10_4000;
  localparam logic [21:0] DEF_DUMP_OFFSET = 22'h10_0000;

endpackage

// File: rtl/jts16_ram_arb_edge.sv
// Rising-edge detector with a sticky pending flag, cleared when the request is granted.
module jts16_ram_arb_edge
  import jts16_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic clr,
  output logic pending
);

  logic level_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_l <= 1'b0;
      pending <= 1'b0;
    end else begin
      level_l <= level;
      // a fresh edge merges into an already pending request
      if (level && !level_l)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/jts16_ram_arb.sv
// Shares one SDRAM bank between CPU work RAM/VRAM accesses and the byte-wide dump read port.
module jts16_ram_arb
  import jts16_ram_arb_pkg::*;
#(
  parameter int            AW          = 22,
  parameter logic [AW-1:0] VRAM_OFFSET = AW'(DEF_VRAM_OFFSET),
  parameter logic [AW-1:0] RAM_OFFSET  = AW'(DEF_RAM_OFFSET),
  parameter logic [AW-1:0] DUMP_OFFSET = AW'(DEF_DUMP_OFFSET)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_cs,
  input  logic          vram_cs,
  input  logic [13:0]   cpu_addr,
  input  logic [15:0]   cpu_dout,
  input  logic [1:0]    dswn,
  output logic [15:0]   ram_data,
  output logic          ram_ok,
  input  logic          ioctl_rd,
  input  logic [15:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_ok,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_wrmask,
  output logic          sdram_we,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [15:0]   sdram_dout
);

  state_t        state, state_nx;
  owner_t        owner, last_grant;
  logic          cpu_cs, cpu_pend, dump_pend;
  logic          grant_cpu, grant_dump;
  logic          alive, owner_lvl, dump_lsb;
  logic [AW-1:0] vram_addr, ram_addr, dump_addr;

  assign cpu_cs    = ram_cs | vram_cs;
  assign owner_lvl = (owner == OWN_CPU) ? cpu_cs : ioctl_rd;
  assign vram_addr = VRAM_OFFSET + AW'(cpu_addr);
  assign ram_addr  = RAM_OFFSET  + AW'(cpu_addr[13:1]);
  assign dump_addr = DUMP_OFFSET + AW'(ioctl_addr[15:1]);

  jts16_ram_arb_edge u_cpu_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (cpu_cs),
    .clr     (grant_cpu),
    .pending (cpu_pend)
  );

  jts16_ram_arb_edge u_dump_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (ioctl_rd),
    .clr     (grant_dump),
    .pending (dump_pend)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant_cpu  = 1'b0;
    grant_dump = 1'b0;
    case (state)
      IDLE: begin
        // with both pending, the side not served last time wins
        if (cpu_pend && (!dump_pend || last_grant == OWN_DUMP)) begin
          grant_cpu = 1'b1;
          state_nx  = REQ;
        end else if (dump_pend) begin
          grant_dump = 1'b1;
          state_nx   = REQ;
        end
      end
      REQ:  if (sdram_ack) state_nx = WAIT;
      WAIT: if (sdram_dst) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_data     <= '1;
      ioctl_din    <= '1;
      ram_ok       <= 1'b0;
      ioctl_ok     <= 1'b0;
      sdram_addr   <= '0;
      sdram_din    <= '0;
      sdram_wrmask <= 2'b11;
      sdram_we     <= 1'b0;
      sdram_req    <= 1'b0;
      owner        <= OWN_CPU;
      last_grant   <= OWN_DUMP;
      alive        <= 1'b0;
      dump_lsb     <= 1'b0;
    end else begin
      ram_ok   <= ram_ok & cpu_cs;
      ioctl_ok <= ioctl_ok & ioctl_rd;
      // once the owner drops its select, this transaction no longer reports back
      alive    <= alive & owner_lvl;
      if (grant_cpu) begin
        owner        <= OWN_CPU;
        last_grant   <= OWN_CPU;
        alive        <= 1'b1;
        sdram_addr   <= vram_cs ? vram_addr : ram_addr;
        sdram_din    <= cpu_dout;
        sdram_we     <= ~&dswn;
        sdram_wrmask <= dswn;
        sdram_req    <= 1'b1;
      end
      if (grant_dump) begin
        owner        <= OWN_DUMP;
        last_grant   <= OWN_DUMP;
        alive        <= 1'b1;
        sdram_addr   <= dump_addr;
        sdram_we     <= 1'b0;
        sdram_wrmask <= 2'b11;
        sdram_req    <= 1'b1;
        dump_lsb     <= ioctl_addr[0];
      end
      if (state == REQ && sdram_ack)
        sdram_req <= 1'b0;
      if (state == WAIT && sdram_dst && alive && owner_lvl) begin
        if (owner == OWN_CPU) begin
          if (!sdram_we) ram_data <= sdram_dout;
        end else begin
          ioctl_din <= dump_lsb ? sdram_dout[15:8] : sdram_dout[7:0];
        end
      end
      if (state == DONE && alive && owner_lvl) begin
        if (owner == OWN_CPU) ram_ok   <= 1'b1;
        else                  ioctl_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jts16_ram_arb.sv
// Bench for jts16_ram_arb: SDRAM responder, word-level memory model, vector table and corner sequences.
module tb_jts16_ram_arb;

  localparam logic [21:0] VRAM_OFF = 22'h10_0000;
  localparam logic [21:0] RAM_OFF  = 22'h10_4000;
  localparam logic [21:0] DUMP_OFF = 22'h10_0000;

  logic        clk, rst_n;
  logic        ram_cs, vram_cs, ioctl_rd;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_dout, ram_data, ioctl_addr, sdram_din, sdram_dout;
  logic [1:0]  dswn, sdram_wrmask;
  logic        ram_ok, ioctl_ok, sdram_we, sdram_req, sdram_ack, sdram_dst;
  logic [7:0]  ioctl_din;
  logic [21:0] sdram_addr;

  typedef struct packed {
    logic [21:0] addr;
    logic        we;
    logic [1:0]  mask;
    logic [15:0] din;
  } tx_t;

  typedef struct packed {
    logic        v;
    logic        r;
    logic [13:0] a;
    logic [1:0]  ds;
    logic [15:0] wd;
    logic [21:0] ea;
    logic        we;
    logic [1:0]  mk;
    logic        crd;
    logic [15:0] rd;
  } vec_t;

  tx_t         tx_q[$];
  logic [15:0] sd_mem    [logic [21:0]];
  logic [15:0] model_mem [logic [21:0]];
  int          ack_dly = 1, dst_dly = 1;
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] exp_ram_data;

  jts16_ram_arb #(
    .AW          (22),
    .VRAM_OFFSET (22'h10_0000),
    .RAM_OFFSET  (22'h10_4000),
    .DUMP_OFFSET (22'h10_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_cs       (ram_cs),
    .vram_cs      (vram_cs),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .dswn         (dswn),
    .ram_data     (ram_data),
    .ram_ok       (ram_ok),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_ok     (ioctl_ok),
    .sdram_addr   (sdram_addr),
    .sdram_din    (sdram_din),
    .sdram_wrmask (sdram_wrmask),
    .sdram_we     (sdram_we),
    .sdram_req    (sdram_req),
    .sdram_ack    (sdram_ack),
    .sdram_dst    (sdram_dst),
    .sdram_dout   (sdram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [21:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] mm_get(input logic [21:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SDRAM side: accepts one request at a time, applies writes, returns data after dst_dly
  initial begin : responder
    tx_t         t;
    int          ad, dd;
    logic [15:0] w;
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b0;
    sdram_dout = '0;
    forever begin
      @(negedge clk);
      if (rst_n && sdram_req) begin
        t.addr = sdram_addr;
        t.we   = sdram_we;
        t.mask = sdram_wrmask;
        t.din  = sdram_din;
        tx_q.push_back(t);
        ad = ack_dly;
        dd = dst_dly;
        w  = sd_mem.exists(t.addr) ? sd_mem[t.addr] : init_val(t.addr);
        if (t.we) begin
          if (!t.mask[1]) w[15:8] = t.din[15:8];
          if (!t.mask[0]) w[7:0]  = t.din[7:0];
          sd_mem[t.addr] = w;
        end
        repeat (ad) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        repeat (dd) @(negedge clk);
        sdram_dout = t.we ? 16'($urandom) : w;
        sdram_dst  = 1'b1;
        @(negedge clk);
        sdram_dst  = 1'b0;
        sdram_dout = 16'($urandom);
      end
    end
  end

  task automatic cpu_access(input logic v, input logic r, input logic [13:0] a,
                            input logic [1:0] ds, input logic [15:0] wd, output tx_t t);
    logic [21:0] ea;
    logic [15:0] w;
    int          n;
    ea = v ? VRAM_OFF + 22'(a) : RAM_OFF + 22'(a[13:1]);
    t  = '0;
    @(negedge clk);
    cpu_addr = a; dswn = ds; cpu_dout = wd; vram_cs = v; ram_cs = r;
    n = 0;
    while (!ram_ok && n < 100) begin @(negedge clk); n++; end
    chk("cpu_ok_timeout", 32'(n < 100), 32'd1);
    chk("cpu_tx_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) t = tx_q.pop_front();
    chk("cpu_addr_map", 32'(t.addr), 32'(ea));
    chk("cpu_we", 32'(t.we), 32'(~&ds));
    chk("cpu_mask", 32'(t.mask), 32'(ds));
    if (!(&ds)) begin
      chk("cpu_din", 32'(t.din), 32'(wd));
      w = mm_get(ea);
      if (!ds[1]) w[15:8] = wd[15:8];
      if (!ds[0]) w[7:0]  = wd[7:0];
      model_mem[ea] = w;
    end else begin
      exp_ram_data = mm_get(ea);
    end
    chk("cpu_ram_data", 32'(ram_data), 32'(exp_ram_data));
    @(negedge clk);
    chk("cpu_ok_hold", 32'(ram_ok), 32'd1);
    ram_cs = 1'b0; vram_cs = 1'b0;
    @(negedge clk);
    chk("cpu_ok_clear", 32'(ram_ok), 32'd0);
  endtask

  task automatic dump_access(input logic [15:0] ia);
    logic [21:0] ea;
    logic [15:0] w;
    tx_t         t;
    int          n;
    ea = DUMP_OFF + 22'(ia[15:1]);
    t  = '0;
    @(negedge clk);
    ioctl_addr = ia; ioctl_rd = 1'b1;
    n = 0;
    while (!ioctl_ok && n < 100) begin @(negedge clk); n++; end
    chk("dump_ok_timeout", 32'(n < 100), 32'd1);
    chk("dump_tx_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) t = tx_q.pop_front();
    chk("dump_addr_map", 32'(t.addr), 32'(ea));
    chk("dump_we", 32'(t.we), 32'd0);
    chk("dump_mask", 32'(t.mask), 32'd3);
    w = mm_get(ea);
    chk("dump_byte", 32'(ioctl_din), ia[0] ? 32'(w[15:8]) : 32'(w[7:0]));
    @(negedge clk);
    chk("dump_ok_hold", 32'(ioctl_ok), 32'd1);
    ioctl_rd = 1'b0;
    @(negedge clk);
    chk("dump_ok_clear", 32'(ioctl_ok), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vec[8];
    tx_t         t;
    logic [15:0] w;
    int          n;
    logic        seen;

    vec[0] = '{1'b1, 1'b0, 14'h0123, 2'b11, 16'h0000, 22'h10_0123, 1'b0, 2'b11, 1'b1, 16'hBEEF};
    vec[1] = '{1'b0, 1'b1, 14'h0010, 2'b10, 16'h1234, 22'h10_4008, 1'b1, 2'b10, 1'b1, 16'hBEEF};
    vec[2] = '{1'b0, 1'b1, 14'h0010, 2'b11, 16'h0000, 22'h10_4008, 1'b0, 2'b11, 1'b1, 16'hE534};
    vec[3] = '{1'b1, 1'b1, 14'h0042, 2'b11, 16'h0000, 22'h10_0042, 1'b0, 2'b11, 1'b0, 16'h0000};
    vec[4] = '{1'b0, 1'b1, 14'h3fff, 2'b01, 16'hABCD, 22'h10_5fff, 1'b1, 2'b01, 1'b0, 16'h0000};
    vec[5] = '{1'b1, 1'b0, 14'h3fff, 2'b00, 16'h5678, 22'h10_3fff, 1'b1, 2'b00, 1'b0, 16'h0000};
    vec[6] = '{1'b1, 1'b0, 14'h3fff, 2'b11, 16'h0000, 22'h10_3fff, 1'b0, 2'b11, 1'b1, 16'h5678};
    vec[7] = '{1'b0, 1'b1, 14'h3fff, 2'b11, 16'h0000, 22'h10_5fff, 1'b0, 2'b11, 1'b1, 16'hAB5A};

    sd_mem[22'h10_0123]    = 16'hBEEF;
    model_mem[22'h10_0123] = 16'hBEEF;

    ram_cs = 1'b0; vram_cs = 1'b0; ioctl_rd = 1'b0;
    cpu_addr = '0; cpu_dout = '0; dswn = 2'b11; ioctl_addr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ram_data", 32'(ram_data), 32'h0000_ffff);
    chk("rst_ioctl_din", 32'(ioctl_din), 32'h0000_00ff);
    chk("rst_ram_ok", 32'(ram_ok), 32'd0);
    chk("rst_ioctl_ok", 32'(ioctl_ok), 32'd0);
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_we", 32'(sdram_we), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_din", 32'(sdram_din), 32'd0);
    chk("rst_mask", 32'(sdram_wrmask), 32'd3);
    rst_n = 1'b1;
    exp_ram_data = 16'hffff;

    // both requesters rise together right after reset: CPU first, then dump
    @(negedge clk);
    cpu_addr = 14'h0100; dswn = 2'b11; ram_cs = 1'b1;
    ioctl_addr = 16'h0003; ioctl_rd = 1'b1;
    n = 0;
    while (!(ram_ok && ioctl_ok) && n < 100) begin @(negedge clk); n++; end
    chk("both_timeout", 32'(n < 100), 32'd1);
    chk("both_tx_count", 32'(tx_q.size()), 32'd2);
    if (tx_q.size() == 2) begin
      chk("both_first_cpu", 32'(tx_q[0].addr), 32'h0010_4080);
      chk("both_second_dump", 32'(tx_q[1].addr), 32'h0010_0001);
      chk("both_dump_we", 32'(tx_q[1].we), 32'd0);
    end
    exp_ram_data = mm_get(22'h10_4080);
    chk("both_ram_data", 32'(ram_data), 32'(exp_ram_data));
    w = mm_get(22'h10_0001);
    chk("both_dump_hi_byte", 32'(ioctl_din), 32'(w[15:8]));
    ram_cs = 1'b0; ioctl_rd = 1'b0;
    @(negedge clk);
    chk("both_ok_clear", 32'({ram_ok, ioctl_ok}), 32'd0);
    tx_q.delete();

    for (int i = 0; i < 8; i++) begin
      cpu_access(vec[i].v, vec[i].r, vec[i].a, vec[i].ds, vec[i].wd, t);
      chk("vec_addr", 32'(t.addr), 32'(vec[i].ea));
      chk("vec_we", 32'(t.we), 32'(vec[i].we));
      chk("vec_mask", 32'(t.mask), 32'(vec[i].mk));
      if (vec[i].crd) chk("vec_rdata", 32'(ram_data), 32'(vec[i].rd));
    end

    // round robin: CPU re-requests during its own transaction while dump waits
    tx_q.delete();
    ack_dly = 3; dst_dly = 1;
    @(negedge clk);
    cpu_addr = 14'h0300; dswn = 2'b00; cpu_dout = 16'hA5A5; ram_cs = 1'b1;
    n = 0;
    while (!sdram_req && n < 50) begin @(negedge clk); n++; end
    chk("rr_req_timeout", 32'(n < 50), 32'd1);
    ioctl_addr = 16'h0010; ioctl_rd = 1'b1;
    @(negedge clk); ram_cs = 1'b0;
    @(negedge clk); ram_cs = 1'b1;
    n = 0;
    while (!ioctl_ok && n < 100) begin @(negedge clk); n++; end
    chk("rr_dump_timeout", 32'(n < 100), 32'd1);
    chk("rr_dump_second", 32'(tx_q.size() >= 2 && tx_q[1].addr == 22'h10_0008 && !tx_q[1].we), 32'd1);
    model_mem[22'h10_4180] = 16'hA5A5;
    w = mm_get(22'h10_0008);
    chk("rr_dump_byte", 32'(ioctl_din), 32'(w[7:0]));
    n = 0;
    while (!ram_ok && n < 100) begin @(negedge clk); n++; end
    chk("rr_cpu_timeout", 32'(n < 100), 32'd1);
    chk("rr_cpu_third", 32'(tx_q.size() == 3 && tx_q[2].addr == 22'h10_4180 && tx_q[2].we), 32'd1);
    chk("rr_ram_data", 32'(ram_data), 32'(exp_ram_data));
    ram_cs = 1'b0; ioctl_rd = 1'b0;
    @(negedge clk);
    chk("rr_ok_clear", 32'({ram_ok, ioctl_ok}), 32'd0);
    tx_q.delete();

    // cs drops between ack and dst: transaction completes silently
    ack_dly = 0; dst_dly = 4;
    @(negedge clk);
    cpu_addr = 14'h0200; dswn = 2'b11; ram_cs = 1'b1;
    n = 0;
    while (!sdram_req && n < 50) begin @(negedge clk); n++; end
    while (sdram_req && n < 50) begin @(negedge clk); n++; end
    chk("drop_ack_timeout", 32'(n < 50), 32'd1);
    ram_cs = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (ram_ok) seen = 1'b1; end
    chk("drop_no_ok", 32'(seen), 32'd0);
    chk("drop_ram_data", 32'(ram_data), 32'(exp_ram_data));
    chk("drop_tx_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) begin
      t = tx_q.pop_front();
      chk("drop_addr", 32'(t.addr), 32'h0010_4100);
    end
    ack_dly = 1; dst_dly = 1;
    cpu_access(1'b0, 1'b1, 14'h0200, 2'b11, 16'h0000, t);

    // asynchronous reset while in REQ, then while in WAIT
    for (int k = 0; k < 2; k++) begin
      ack_dly = (k == 0) ? 8 : 0;
      dst_dly = (k == 0) ? 1 : 6;
      @(negedge clk);
      cpu_addr = 14'h0055; dswn = 2'b11; vram_cs = 1'b1;
      n = 0;
      while (!sdram_req && n < 50) begin @(negedge clk); n++; end
      if (k == 1) while (sdram_req && n < 50) begin @(negedge clk); n++; end
      chk("rstmid_timeout", 32'(n < 50), 32'd1);
      rst_n = 1'b0; vram_cs = 1'b0;
      #1;
      chk("rstmid_req", 32'(sdram_req), 32'd0);
      chk("rstmid_oks", 32'({ram_ok, ioctl_ok}), 32'd0);
      chk("rstmid_ram_data", 32'(ram_data), 32'h0000_ffff);
      repeat (16) @(negedge clk);
      rst_n = 1'b1;
      exp_ram_data = 16'hffff;
      tx_q.delete();
      ack_dly = 1; dst_dly = 1;
      cpu_access(1'b1, 1'b0, 14'h0055, 2'b11, 16'h0000, t);
    end

    // randomized traffic over a small window so reads revisit earlier writes
    for (int i = 0; i < 60; i++) begin
      ack_dly = $urandom_range(0, 3);
      dst_dly = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: cpu_access(1'b1, 1'b0, 14'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), t);
        1: cpu_access(1'b0, 1'b1, 14'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), t);
        2: cpu_access(1'b1, 1'b1, 14'($urandom_range(0, 15)), 2'($urandom), 16'($urandom), t);
        default: dump_access(16'($urandom_range(0, 31)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
